// File: rtl/wide_add_seq.sv
// Multi-cycle wide add/subtract sequencer that walks a narrow external ALU
// one slice per cycle, least-significant slice first, rippling the carry.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; ALU inputs held at 0
// RUN   | one slice per cycle through the ALU, carry rippled in carry_reg
// DONE  | one-cycle completion pulse; result/carry/zero just updated
module wide_add_seq #(
    parameter int TERMINAL_RANGE = 8,
    parameter int BYTES          = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              op,
    input  logic [TERMINAL_RANGE*BYTES-1:0]   a,
    input  logic [TERMINAL_RANGE*BYTES-1:0]   b,
    output logic                              busy,
    output logic                              done,
    output logic [TERMINAL_RANGE*BYTES-1:0]   result,
    output logic                              carry,
    output logic                              zero,
    output logic [TERMINAL_RANGE-1:0]         alu_a,
    output logic [TERMINAL_RANGE-1:0]         alu_b,
    output logic                              alu_cin,
    input  logic [TERMINAL_RANGE-1:0]         alu_product,
    input  logic                              alu_cout,
    input  logic                              alu_zero
);

    localparam int W  = TERMINAL_RANGE * BYTES;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_lat;
    logic [W-1:0]    b_lat;
    logic [W-1:0]    work;
    logic [W-1:0]    work_next;
    logic [IW-1:0]   idx;
    logic            carry_reg;
    logic            zacc;

    // The final slice is merged here so result picks it up on the same edge.
    always_comb begin
        work_next = work;
        work_next[int'(idx)*TERMINAL_RANGE +: TERMINAL_RANGE] = alu_product;
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        if (state == S_RUN) begin
            alu_a   = a_lat[int'(idx)*TERMINAL_RANGE +: TERMINAL_RANGE];
            alu_b   = b_lat[int'(idx)*TERMINAL_RANGE +: TERMINAL_RANGE];
            alu_cin = carry_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            work      <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            zacc      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b here, seed carry with op.
                        a_lat     <= a;
                        b_lat     <= op ? ~b : b;
                        idx       <= '0;
                        carry_reg <= op;
                        zacc      <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    work      <= work_next;
                    carry_reg <= alu_cout;
                    zacc      <= zacc & alu_zero;
                    idx       <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        result <= work_next;
                        carry  <= alu_cout;
                        zero   <= zacc & alu_zero;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq: behavioural 8-bit ALU, directed vector table,
// hand-written corner sequences and randomized ops against an arithmetic model.
module tb_wide_add_seq;

    localparam int TR = 8;
    localparam int NB = 2;
    localparam int W  = TR * NB;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;
    logic [TR-1:0] alu_a;
    logic [TR-1:0] alu_b;
    logic          alu_cin;
    logic [TR-1:0] alu_product;
    logic          alu_cout;
    logic          alu_zero;

    int n_chk  = 0;
    int n_fail = 0;

    wide_add_seq #(.TERMINAL_RANGE(TR), .BYTES(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .carry       (carry),
        .zero        (zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_product (alu_product),
        .alu_cout    (alu_cout),
        .alu_zero    (alu_zero)
    );

    // Downstream ALU with its op-select tied to add.
    assign {alu_cout, alu_product} = {1'b0, alu_a} + {1'b0, alu_b} + {{TR{1'b0}}, alu_cin};
    assign alu_zero = (alu_product == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vop;
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic; carry for subtract means no borrow.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        if (!o) begin
            s = {1'b0, x} + {1'b0, y};
            r = s[W-1:0];
            c = s[W];
        end else begin
            r = x - y;
            c = (x >= y);
        end
        return {(r == '0), c, r};
    endfunction

    // Issues one op, scrambles inputs while it runs, checks done timing and outputs.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic top, input logic [W-1:0] eres, input logic ec, input logic ez);
        start = 1'b1;
        a     = ta;
        b     = tb2;
        op    = top;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 1'($urandom);
        check({name, " busy in RUN"}, 64'(busy), 64'(1));
        for (int k = 0; k < NB; k++) begin
            check({name, " done early"}, 64'(done), 64'(0));
            tick();
        end
        check({name, " done pulse"}, 64'(done), 64'(1));
        check({name, " result"}, 64'(result), 64'(eres));
        check({name, " carry"}, 64'(carry), 64'(ec));
        check({name, " zero"}, 64'(zero), 64'(ez));
        tick();
        check({name, " done cleared"}, 64'(done), 64'(0));
        check({name, " busy cleared"}, 64'(busy), 64'(0));
    endtask

    vec_t          vecs[8];
    logic [W+1:0]  m;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          rop;

    initial begin
        vecs[0] = '{"add 12FF+0001", 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0};
        vecs[1] = '{"sub 1234-1234", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{"sub 0000-0001", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{"add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{"sub 8000-7FFF", 16'h8000, 16'h7FFF, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{"add 00FF+0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{"add 7FFF+8001", 16'h7FFF, 16'h8001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{"sub 0100-0001", 16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset carry", 64'(carry), 64'(0));
        check("reset zero", 64'(zero), 64'(0));
        check("reset alu_a", 64'(alu_a), 64'(0));
        check("reset alu_b", 64'(alu_b), 64'(0));
        check("reset alu_cin", 64'(alu_cin), 64'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].res, vecs[i].c, vecs[i].z);

        // Slice-level view of 12FF+0001: carry out of slice 0 feeds slice 1.
        start = 1'b1; a = 16'h12FF; b = 16'h0001; op = 1'b0;
        tick();
        start = 1'b0;
        check("add slice0 alu_a", 64'(alu_a), 64'h FF);
        check("add slice0 alu_cin", 64'(alu_cin), 64'(0));
        check("add slice0 alu_cout", 64'(alu_cout), 64'(1));
        tick();
        check("add slice1 alu_a", 64'(alu_a), 64'h12);
        check("add slice1 alu_cin", 64'(alu_cin), 64'(1));
        tick();
        check("add DONE alu_a", 64'(alu_a), 64'(0));
        check("add DONE alu_cin", 64'(alu_cin), 64'(0));
        tick();

        // Slice-level view of 1234-1234: b inverted, carry-in seeded with 1.
        start = 1'b1; a = 16'h1234; b = 16'h1234; op = 1'b1;
        tick();
        start = 1'b0;
        check("sub slice0 alu_b", 64'(alu_b), 64'hCB);
        check("sub slice0 alu_cin", 64'(alu_cin), 64'(1));
        tick();
        check("sub slice1 alu_b", 64'(alu_b), 64'hED);
        tick();
        check("sub DONE alu_b", 64'(alu_b), 64'(0));
        tick();

        // start held through RUN and DONE with other operands, then back-to-back.
        start = 1'b1; a = 16'h1111; b = 16'h2222; op = 1'b0;
        tick();
        a = 16'hAAAA; b = 16'h5555; op = 1'b1;
        tick();
        tick();
        check("ignore done", 64'(done), 64'(1));
        check("ignore result", 64'(result), 64'h3333);
        check("ignore carry", 64'(carry), 64'(0));
        tick();
        check("b2b idle busy", 64'(busy), 64'(0));
        tick();
        start = 1'b0;
        check("b2b accepted busy", 64'(busy), 64'(1));
        check("b2b result held", 64'(result), 64'h3333);
        tick();
        check("b2b result held 2", 64'(result), 64'h3333);
        tick();
        check("b2b done", 64'(done), 64'(1));
        check("b2b result", 64'(result), 64'h5555);
        check("b2b carry", 64'(carry), 64'(1));
        tick();

        // Reset mid-RUN aborts with no done pulse.
        start = 1'b1; a = 16'h4321; b = 16'h1111; op = 1'b0;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'(0));
        check("abort result", 64'(result), 64'(0));
        check("abort alu_a", 64'(alu_a), 64'(0));
        #4 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort no done", 64'(done), 64'(0));
        end
        run_op("add 0102+0304", 16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra  = W'($urandom);
            rb  = (i % 5 == 0) ? ra : W'($urandom);
            rop = 1'($urandom);
            m   = model(ra, rb, rop);
            run_op("random", ra, rb, rop, m[W-1:0], m[W], m[W+1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
